// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx
//   Transmit side of a single-bit serial line. A parallel word is taken over a
//   valid/ready handshake and shifted out MSB first, one bit per clock. The
//   0->1 transitions on the line during each word are counted, so a bench can
//   compare against a downstream rising-transition detector.
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   load_valid  load_data is valid
//   load_data   word to send, bit WIDTH-1 first
//   load_ready  block can accept a word (IDLE only)
//   tx_bit      serial line
//   tx_active   a word bit is on tx_bit this cycle
//   done        1-cycle pulse after the last bit of a word
//   edge_count  0->1 transitions in the last completed word
module serial_pattern_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GAP   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_valid,
  input  logic [WIDTH-1:0]           load_data,
  output logic                       load_ready,
  output logic                       tx_bit,
  output logic                       tx_active,
  output logic                       done,
  output logic [$clog2(WIDTH+1)-1:0] edge_count
);

  localparam int unsigned CW   = $clog2(WIDTH + 1);
  localparam int unsigned GAPW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_bitcnt;
  logic [CW-1:0]    r_edge_run;
  logic [CW-1:0]    r_edge_count;
  logic [GAPW-1:0]  r_gapcnt;
  logic             r_tx_bit, r_tx_active, r_done, r_first;
  logic             w_accept, w_last_bit, w_next_bit, w_rise;

  assign tx_bit     = r_tx_bit;
  assign tx_active  = r_tx_active;
  assign done       = r_done;
  assign edge_count = r_edge_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_last_bit = 1'b0;
    load_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          w_accept = 1'b1;
          w_next   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_bitcnt == CW'(WIDTH)) begin
          w_last_bit = 1'b1;
          w_next     = (GAP == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (r_gapcnt == GAPW'(GAP - 1)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // The bit about to go on the line is compared with the held line value,
    // so transitions across word boundaries are counted too.
    w_next_bit = w_accept ? load_data[WIDTH-1] : r_shift[WIDTH-1];
    w_rise     = w_next_bit & ~r_tx_bit & ~r_first;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift      <= '0;
      r_bitcnt     <= '0;
      r_edge_run   <= '0;
      r_edge_count <= '0;
      r_gapcnt     <= '0;
      r_tx_bit     <= 1'b0;
      r_tx_active  <= 1'b0;
      r_done       <= 1'b0;
      r_first      <= 1'b1;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_tx_bit    <= load_data[WIDTH-1];
        r_shift     <= load_data << 1;
        r_tx_active <= 1'b1;
        r_bitcnt    <= CW'(1);
        r_edge_run  <= CW'(w_rise);
        r_first     <= 1'b0;
      end else if (r_state == S_SHIFT) begin
        if (w_last_bit) begin
          r_tx_active  <= 1'b0;
          r_done       <= 1'b1;
          r_edge_count <= r_edge_run;
          r_gapcnt     <= '0;
        end else begin
          r_tx_bit   <= r_shift[WIDTH-1];
          r_shift    <= r_shift << 1;
          r_bitcnt   <= r_bitcnt + CW'(1);
          r_edge_run <= r_edge_run + CW'(w_rise);
        end
      end else if (r_state == S_GAP) begin
        r_gapcnt <= r_gapcnt + GAPW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: u1 uses GAP=1, u0 uses GAP=0 (back-to-back).
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lv1 = 1'b0, lv0 = 1'b0;
  logic [7:0] ld1 = '0, ld0 = '0;
  logic       rdy1, bit1, act1, done1;
  logic       rdy0, bit0, act0, done0;
  logic [3:0] ec1, ec0;

  int total = 0;
  int bad   = 0;

  // Reference state: held line value and "first bit after reset" flag.
  logic m_line1, m_first1, m_line0, m_first0;

  always #5 clk = ~clk;

  serial_pattern_tx #(.WIDTH(8), .GAP(1)) u1 (
    .clk(clk), .reset(rst_n), .load_valid(lv1), .load_data(ld1),
    .load_ready(rdy1), .tx_bit(bit1), .tx_active(act1), .done(done1),
    .edge_count(ec1)
  );

  serial_pattern_tx #(.WIDTH(8), .GAP(0)) u0 (
    .clk(clk), .reset(rst_n), .load_valid(lv0), .load_data(ld0),
    .load_ready(rdy0), .tx_bit(bit0), .tx_active(act0), .done(done0),
    .edge_count(ec0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Count 0->1 transitions a word creates on a line currently at 'line'.
  function automatic int model_edges(input logic [7:0] d, input logic line, input logic first);
    int   n = 0;
    logic prev = line;
    for (int i = 7; i >= 0; i--) begin
      if (d[i] && !prev && !(first && i == 7)) n++;
      prev = d[i];
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_line1 = 1'b0; m_first1 = 1'b1;
    m_line0 = 1'b0; m_first0 = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; lv1 = 1'b0; lv0 = 1'b0;
    tick(); tick();
    chk("rst_ready1", rdy1, 1); chk("rst_bit1", bit1, 0); chk("rst_act1", act1, 0);
    chk("rst_done1", done1, 0); chk("rst_ec1", ec1, 0);
    chk("rst_ready0", rdy0, 1); chk("rst_bit0", bit0, 0); chk("rst_ec0", ec0, 0);
    rst_n = 1'b1;
    tick();
    model_reset();
  endtask

  // One word on u1 (GAP=1); poke pulses load_valid mid-word, which must be ignored.
  task automatic send1(input logic [7:0] d, input bit poke, output int edges);
    chk("ready_before", rdy1, 1);
    lv1 = 1'b1; ld1 = d;
    tick();
    lv1 = 1'b0; ld1 = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      if (poke && i == 3) begin lv1 = 1'b1; ld1 = 8'h01; end
      if (poke && i == 4) lv1 = 1'b0;
      chk("shift_bit", bit1, d[7-i]);
      chk("shift_act", act1, 1);
      chk("shift_ready", rdy1, 0);
      chk("shift_done", done1, 0);
      tick();
    end
    chk("done_pulse", done1, 1);
    chk("done_act", act1, 0);
    chk("done_ready", rdy1, 0);
    chk("done_hold", bit1, d[0]);
    edges = int'(ec1);
    tick();
    chk("gap_end_done", done1, 0);
    chk("gap_end_ready", rdy1, 1);
    chk("gap_end_hold", bit1, d[0]);
  endtask

  // Back-to-back stream on u0 (GAP=0) with load_valid held high.
  task automatic stream0(input logic [7:0] w [$]);
    lv0 = 1'b1; ld0 = w[0];
    for (int j = 0; j < w.size(); j++) begin
      chk("s0_ready_acc", rdy0, 1);
      tick();
      if (j + 1 < w.size()) ld0 = w[j+1];
      else                  lv0 = 1'b0;
      for (int i = 0; i < 8; i++) begin
        chk("s0_bit", bit0, w[j][7-i]);
        chk("s0_act", act0, 1);
        chk("s0_ready", rdy0, 0);
        tick();
      end
      chk("s0_done", done0, 1);
      chk("s0_done_act", act0, 0);
      chk("s0_done_hold", bit0, w[j][0]);
      chk("s0_edges", ec0, model_edges(w[j], m_line0, m_first0));
      m_line0 = w[j][0]; m_first0 = 1'b0;
    end
    tick();
    chk("s0_after_done", done0, 0);
    chk("s0_after_act", act0, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         rst_before;
    int         exp_edges;
  } vec_t;

  vec_t       vt [4];
  int         e;
  logic [7:0] d;
  logic [7:0] q [$];

  initial begin
    vt[0] = '{8'b0011_0101, 1'b1, 3};
    vt[1] = '{8'b1000_0001, 1'b1, 1};
    vt[2] = '{8'b1111_1111, 1'b0, 0};
    vt[3] = '{8'b0101_0101, 1'b0, 4};

    model_reset();
    do_reset();

    for (int v = 0; v < 4; v++) begin
      if (vt[v].rst_before) do_reset();
      send1(vt[v].data, 1'b0, e);
      chk("vec_edges", e, vt[v].exp_edges);
      m_line1 = vt[v].data[0]; m_first1 = 1'b0;
    end
    chk("line_held_1", bit1, 1);

    // Back-to-back on GAP=0: 00 consumes the first-bit flag, then A5, 5A.
    q = '{8'h00, 8'hA5, 8'h5A};
    stream0(q);

    // Reset during the 4th bit of FF aborts the word without a done pulse.
    chk("abort_ready", rdy1, 1);
    lv1 = 1'b1; ld1 = 8'hFF;
    tick();
    lv1 = 1'b0;
    tick(); tick(); tick();
    chk("abort_bit4", bit1, 1);
    chk("abort_act4", act1, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_bit", bit1, 0);
    chk("abort_act", act1, 0);
    chk("abort_ready_now", rdy1, 1);
    chk("abort_ec", ec1, 0);
    tick();
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      chk("abort_no_done", done1, 0);
      chk("abort_idle_act", act1, 0);
      tick();
    end
    send1(8'h80, 1'b0, e);
    chk("first_after_abort", e, model_edges(8'h80, m_line1, m_first1));
    m_line1 = 1'b0; m_first1 = 1'b0;

    // load_valid during SHIFT is ignored.
    send1(8'h3C, 1'b1, e);
    chk("poke_edges", e, model_edges(8'h3C, m_line1, m_first1));
    m_line1 = 1'b0;
    tick();
    chk("poke_no_second", act1, 0);

    // Randomized words on u1 with random idle spacing and occasional reset.
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 7) == 0) do_reset();
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        chk("rnd_idle_act", act1, 0);
        chk("rnd_idle_line", bit1, m_line1);
        tick();
      end
      d = 8'($urandom);
      send1(d, $urandom_range(0, 3) == 0, e);
      chk("rnd_edges", e, model_edges(d, m_line1, m_first1));
      m_line1 = d[0]; m_first1 = 1'b0;
    end

    // Randomized back-to-back burst on u0.
    q.delete();
    for (int n = 0; n < 6; n++) q.push_back(8'($urandom));
    stream0(q);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
